// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Holds the load/store size encodings (funct3) and the FSM state encoding.
package mem_access_stage_pkg;

  // funct3 size/sign encodings for loads and stores
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Memory-stage FSM states
  typedef enum logic [1:0] {
    MEM_IDLE   = 2'b00,
    MEM_ACCESS = 2'b01,
    MEM_DONE   = 2'b10
  } memState_t;

  // Access width, independent of signedness
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } accSize_t;

  // Undefined funct3 encodings fall through to a full-word access.
  function automatic accSize_t accSize(input logic [2:0] funct3);
    case (funct3)
      LS_B, LS_BU: return SZ_B;
      LS_H, LS_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
// master = pipeline side (issues requests), slave = memory side.
interface mem_access_stage_if #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [BE_W-1:0] be;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access_stage_load_formatter.sv
// Combinational load-data formatter: picks the byte/half lane addressed by
// the low address bits and sign- or zero-extends it. Full words pass through.
// Halfword lane selection uses only off[1], so an odd halfword address reads
// the aligned halfword that contains it.
module mem_access_stage_load_formatter
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Lane select followed by extension according to funct3
  always_comb begin
    byteLane = rdata[{off, 3'b000} +: 8];
    halfLane = rdata[{off[1], 4'b0000} +: 16];
    case (funct3)
      LS_B:    result = {{(XLEN-8){byteLane[7]}}, byteLane};
      LS_BU:   result = {{(XLEN-8){1'b0}}, byteLane};
      LS_H:    result = {{(XLEN-16){halfLane[15]}}, halfLane};
      LS_HU:   result = {{(XLEN-16){1'b0}}, halfLane};
      LS_W:    result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage of the RV32I pipeline: turns EX/MEM load/store control into a
// req/ack transaction on the data-memory bus, stalls the upstream pipeline
// while the transaction is outstanding, and formats load data for MEM/WB.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses issue no
// request and raise fault_o for one cycle instead of being silently aligned.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            memRead_i,
  input  logic            memWrite_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] storeData_i,
  mem_access_stage_if.master dmem,
  output logic            stall_o,
  output logic [XLEN-1:0] rdData_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            fault_o
`endif
);

  memState_t       stateReg, stateNext;
  logic [XLEN-1:0] addrReg;
  logic [XLEN-1:0] wdataReg;
  logic [BE_W-1:0] beReg;
  logic            weReg;
  logic [1:0]      offReg;
  logic [2:0]      funct3Reg;
  logic [XLEN-1:0] rdDataReg;
  logic [XLEN-1:0] loadFmt;

  logic            acc;
  logic            start;
  accSize_t        size;
  logic [1:0]      off;
  logic [XLEN-1:0] wdataByte;
  logic [XLEN-1:0] wdataHalf;
  logic [XLEN-1:0] wdataFmt;
  logic [BE_W-1:0] beFmt;

  assign acc   = valid_i & (memRead_i | memWrite_i);
  assign start = (stateReg == MEM_IDLE) & acc;
  assign size  = accSize(funct3_i);
  assign off   = addr_i[1:0];

  // Store data is replicated across every lane so memory can pick any one.
  genvar gi;
  for (gi = 0; gi < BE_W; gi++) begin : g_byteRep
    assign wdataByte[gi*8 +: 8] = storeData_i[7:0];
  end
  for (gi = 0; gi < BE_W / 2; gi++) begin : g_halfRep
    assign wdataHalf[gi*16 +: 16] = storeData_i[15:0];
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  logic faultReg;
  assign misalign = ((size == SZ_H) & off[0]) | ((size == SZ_W) & (off != 2'b00));
  assign fault_o  = faultReg;
`endif

  // Store lane formatting: byte enables from the size and low address bits
  always_comb begin
    wdataFmt = storeData_i;
    beFmt    = '1;
    case (size)
      SZ_B: begin
        wdataFmt = wdataByte;
        beFmt    = BE_W'(1) << off;
      end
      SZ_H: begin
        wdataFmt = wdataHalf;
        beFmt    = BE_W'(3) << {off[1], 1'b0};
      end
      default: begin
        wdataFmt = storeData_i;
        beFmt    = '1;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) stateReg <= MEM_IDLE;
    else     stateReg <= stateNext;
  end

  // FSM next state and stall; DONE always releases the pipeline for one cycle
  always_comb begin
    stateNext = stateReg;
    stall_o   = 1'b0;
    unique case (stateReg)
      MEM_IDLE: begin
        if (acc) begin
          stall_o   = 1'b1;
          stateNext = MEM_ACCESS;
`ifdef MISALIGN_TRAP_EN
          if (misalign) stateNext = MEM_DONE;
`endif
        end
      end
      MEM_ACCESS: begin
        stall_o = 1'b1;
        if (dmem.ack) stateNext = MEM_DONE;
      end
      MEM_DONE: stateNext = MEM_IDLE;
      default:  stateNext = MEM_IDLE;
    endcase
  end

  // Capture the request on entry, then the formatted load result on ack
  always_ff @(posedge clk) begin
    if (rst) begin
      addrReg   <= '0;
      wdataReg  <= '0;
      beReg     <= '0;
      weReg     <= 1'b0;
      offReg    <= 2'b00;
      funct3Reg <= 3'b000;
      rdDataReg <= '0;
    end else begin
      if (start) begin
        addrReg   <= {addr_i[XLEN-1:2], 2'b00};
        wdataReg  <= wdataFmt;
        beReg     <= beFmt;
        weReg     <= memWrite_i;
        offReg    <= off;
        funct3Reg <= funct3_i;
      end
      if ((stateReg == MEM_ACCESS) && dmem.ack && !weReg) rdDataReg <= loadFmt;
`ifdef MISALIGN_TRAP_EN
      if (start && misalign) rdDataReg <= '0;
`endif
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Fault is raised on the IDLE->DONE hop and therefore lasts exactly DONE
  always_ff @(posedge clk) begin
    if (rst) faultReg <= 1'b0;
    else     faultReg <= start & misalign;
  end
`endif

  mem_access_stage_load_formatter #(.XLEN(XLEN)) u_loadFmt (
    .rdata  (dmem.rdata),
    .off    (offReg),
    .funct3 (funct3Reg),
    .result (loadFmt)
  );

  assign dmem.req   = (stateReg == MEM_ACCESS);
  assign dmem.we    = weReg & (stateReg == MEM_ACCESS);
  assign dmem.addr  = addrReg;
  assign dmem.wdata = wdataReg;
  assign dmem.be    = beReg;
  assign rdData_o   = rdDataReg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage. Expected values are hand-computed.
// Honours MISALIGN_TRAP_EN for the misaligned-load case.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        memRead_i;
  logic        memWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] storeData_i;
  logic        stall_o;
  logic [31:0] rdData_o;
`ifdef MISALIGN_TRAP_EN
  logic        fault_o;
`endif

  int errCount   = 0;
  int checkCount = 0;

  mem_access_stage_if #(.XLEN(32), .BE_W(4)) dmemBus();

  mem_access_stage #(.XLEN(32), .BE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .memRead_i   (memRead_i),
    .memWrite_i  (memWrite_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .storeData_i (storeData_i),
    .dmem        (dmemBus),
    .stall_o     (stall_o),
    .rdData_o    (rdData_o)
`ifdef MISALIGN_TRAP_EN
    ,
    .fault_o     (fault_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    valid_i     = 1'b0;
    memRead_i   = 1'b0;
    memWrite_i  = 1'b0;
    funct3_i    = 3'b010;
    addr_i      = 32'h0;
    storeData_i = 32'h0;
  endtask

  // One full transaction from IDLE through DONE, leaving the DUT in IDLE
  task automatic runAccess(input string tag, input logic isRead, input logic isWrite,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdw, input int ackWait,
                           input logic [31:0] expAddr, input logic [31:0] expWdata,
                           input logic [3:0] expBe, input logic [31:0] expRd);
    int reqCnt;
    reqCnt      = 0;
    valid_i     = 1'b1;
    memRead_i   = isRead;
    memWrite_i  = isWrite;
    funct3_i    = f3;
    addr_i      = a;
    storeData_i = sd;
    #1;
    check({tag, " idle stall"}, 32'(stall_o), 32'd1);
    check({tag, " idle req"}, 32'(dmemBus.req), 32'd0);
    cyc();
    for (int k = 0; k <= ackWait; k++) begin
      dmemBus.ack   = (k == ackWait);
      dmemBus.rdata = (k == ackWait) ? rdw : 32'hA5A5_A5A5;
      #1;
      check({tag, " acc stall"}, 32'(stall_o), 32'd1);
      check({tag, " acc addr"}, dmemBus.addr, expAddr);
      if (dmemBus.req) reqCnt++;
      if (k == 0) begin
        check({tag, " we"}, 32'(dmemBus.we), 32'(isWrite));
        if (isWrite) begin
          check({tag, " wdata"}, dmemBus.wdata, expWdata);
          check({tag, " be"}, 32'(dmemBus.be), 32'(expBe));
        end
      end
      cyc();
    end
    dmemBus.ack   = 1'b0;
    dmemBus.rdata = 32'h0;
    #1;
    check({tag, " req cycles"}, 32'(reqCnt), 32'(ackWait + 1));
    check({tag, " done stall"}, 32'(stall_o), 32'd0);
    check({tag, " done req"}, 32'(dmemBus.req), 32'd0);
    check({tag, " rdData"}, rdData_o, expRd);
    cyc();
    bubble();
  endtask

  initial begin
    rst           = 1'b1;
    dmemBus.ack   = 1'b0;
    dmemBus.rdata = 32'h0;
    bubble();
    cyc();
    cyc();
    check("rst req", 32'(dmemBus.req), 32'd0);
    check("rst we", 32'(dmemBus.we), 32'd0);
    check("rst stall", 32'(stall_o), 32'd0);
    check("rst addr", dmemBus.addr, 32'd0);
    check("rst wdata", dmemBus.wdata, 32'd0);
    check("rst be", 32'(dmemBus.be), 32'd0);
    check("rst rdData", rdData_o, 32'd0);
`ifdef MISALIGN_TRAP_EN
    check("rst fault", 32'(fault_o), 32'd0);
`endif
    rst = 1'b0;
    cyc();

    // Non-memory instruction and a bubble carrying memRead: no stall, no request
    valid_i = 1'b1;
    #1;
    check("alu stall", 32'(stall_o), 32'd0);
    check("alu req", 32'(dmemBus.req), 32'd0);
    cyc();
    valid_i   = 1'b0;
    memRead_i = 1'b1;
    #1;
    check("bubble stall", 32'(stall_o), 32'd0);
    cyc();
    check("bubble req", 32'(dmemBus.req), 32'd0);
    bubble();

    // LW, ack on the third request cycle
    runAccess("LW100", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2,
              32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF);
    // Byte loads at offset 3, signed then unsigned
    runAccess("LB103", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0,
              32'h100, 32'h0, 4'h0, 32'hFFFF_FF80);
    runAccess("LBU103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 0,
              32'h100, 32'h0, 4'h0, 32'h0000_0080);
    // Halfword loads: upper lane signed, lower lane unsigned
    runAccess("LH102", 1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 1,
              32'h100, 32'h0, 4'h0, 32'hFFFF_8001);
    runAccess("LHU100", 1, 0, 3'b101, 32'h100, 32'h0, 32'h1234_F00D, 0,
              32'h100, 32'h0, 4'h0, 32'h0000_F00D);
    // Stores leave rdData untouched
    runAccess("SH202", 0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0,
              32'h200, 32'hABCD_ABCD, 4'b1100, 32'h0000_F00D);
    runAccess("SB001", 0, 1, 3'b000, 32'h001, 32'h0000_005A, 32'h0, 0,
              32'h000, 32'h5A5A_5A5A, 4'b0010, 32'h0000_F00D);
    runAccess("SW040", 0, 1, 3'b010, 32'h040, 32'hCAFE_F00D, 32'h0, 1,
              32'h040, 32'hCAFE_F00D, 4'b1111, 32'h0000_F00D);
    // Read and write both set behaves as a store
    runAccess("RWboth", 1, 1, 3'b010, 32'h080, 32'h0BAD_C0DE, 32'h1111_1111, 0,
              32'h080, 32'h0BAD_C0DE, 4'b1111, 32'h0000_F00D);
    // Undefined funct3 011 behaves as W
    runAccess("LD011", 1, 0, 3'b011, 32'h110, 32'h0, 32'h7654_3210, 0,
              32'h110, 32'h0, 4'h0, 32'h7654_3210);
    // Back-to-back LWs with immediate ack: stall 1,1,0,1,1,0
    runAccess("B2B1", 1, 0, 3'b010, 32'h300, 32'h0, 32'h0000_0001, 0,
              32'h300, 32'h0, 4'h0, 32'h0000_0001);
    runAccess("B2B2", 1, 0, 3'b010, 32'h304, 32'h0, 32'h0000_0002, 0,
              32'h304, 32'h0, 4'h0, 32'h0000_0002);

    // Reset while waiting for ack; a late ack must be ignored
    valid_i   = 1'b1;
    memRead_i = 1'b1;
    funct3_i  = 3'b010;
    addr_i    = 32'h400;
    cyc();
    check("rstmid req before", 32'(dmemBus.req), 32'd1);
    rst = 1'b1;
    bubble();
    cyc();
    rst = 1'b0;
    check("rstmid req", 32'(dmemBus.req), 32'd0);
    check("rstmid stall", 32'(stall_o), 32'd0);
    check("rstmid rdData", rdData_o, 32'd0);
    dmemBus.ack   = 1'b1;
    dmemBus.rdata = 32'hFEED_FACE;
    cyc();
    dmemBus.ack   = 1'b0;
    check("late ack rdData", rdData_o, 32'd0);
    check("late ack req", 32'(dmemBus.req), 32'd0);
    cyc();

    // Misaligned LW at 0x102
`ifdef MISALIGN_TRAP_EN
    runAccess("LWpre", 1, 0, 3'b010, 32'h100, 32'h0, 32'h1357_9BDF, 0,
              32'h100, 32'h0, 4'h0, 32'h1357_9BDF);
    valid_i   = 1'b1;
    memRead_i = 1'b1;
    funct3_i  = 3'b010;
    addr_i    = 32'h102;
    #1;
    check("mis idle stall", 32'(stall_o), 32'd1);
    check("mis idle req", 32'(dmemBus.req), 32'd0);
    cyc();
    check("mis done req", 32'(dmemBus.req), 32'd0);
    check("mis done stall", 32'(stall_o), 32'd0);
    check("mis fault", 32'(fault_o), 32'd1);
    check("mis rdData", rdData_o, 32'd0);
    cyc();
    bubble();
    #1;
    check("mis fault clear", 32'(fault_o), 32'd0);
    check("mis after req", 32'(dmemBus.req), 32'd0);
    cyc();
`else
    runAccess("LW102", 1, 0, 3'b010, 32'h102, 32'h0, 32'h1122_3344, 0,
              32'h100, 32'h0, 4'h0, 32'h1122_3344);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
